router_fsm: RTL

- Packet-reception controller for the 1x3 router.
- Sequences the header, payload, parity and full-stall phases of each incoming packet.
- Drives the register block's load strobes and the sync block's detect_add / we_reg.
- Consumes FIFO status (empty0..2, fifo_full) and the per-port soft resets (sr0..2).

---
 rtl/router_fsm.sv | 134 +++++++++++++
 1 files changed

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router: sequences header, payload,
// parity and full-stall phases and decodes the per-state strobes.
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       empty0,
  input  logic       empty1,
  input  logic       empty2,
  input  logic       sr0,
  input  logic       sr1,
  input  logic       sr2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       we_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cur_addr_q, cur_addr_d;
  logic       hdr_ok;
  logic       din_empty;
  logic       cur_empty;
  logic       cur_sr;

  assign hdr_ok = pkt_valid && (din != 2'd3);

  // Port-select muxes: header address picks the FIFO while decoding,
  // the latched address is used for the rest of the packet.
  always_comb begin
    din_empty = 1'b0;
    cur_empty = 1'b0;
    cur_sr    = 1'b0;
    case (din)
      2'd0:    din_empty = empty0;
      2'd1:    din_empty = empty1;
      2'd2:    din_empty = empty2;
      default: din_empty = 1'b0;
    endcase
    case (cur_addr_q)
      2'd0:    begin cur_empty = empty0; cur_sr = sr0; end
      2'd1:    begin cur_empty = empty1; cur_sr = sr1; end
      2'd2:    begin cur_empty = empty2; cur_sr = sr2; end
      default: begin cur_empty = 1'b0;   cur_sr = 1'b0; end
    endcase
  end

  always_comb begin
    cur_addr_d = cur_addr_q;
    if (state_q == DECODE_ADDRESS && hdr_ok)
      cur_addr_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DECODE_ADDRESS;
      cur_addr_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DECODE_ADDRESS:
        if (hdr_ok) state_d = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:
        state_d = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      LOAD_PARITY:
        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:
        if (cur_empty) state_d = LOAD_FIRST_DATA;
      default:
        state_d = DECODE_ADDRESS;
    endcase
    // A read timeout on the active port abandons the packet from any phase.
    if (state_q != DECODE_ADDRESS && cur_sr)
      state_d = DECODE_ADDRESS;
  end

  always_comb begin
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    we_reg      = 1'b0;
    rst_int_reg = 1'b0;
    busy        = 1'b1;
    case (state_q)
      DECODE_ADDRESS:     begin detect_add = 1'b1; busy = 1'b0; end
      LOAD_FIRST_DATA:    lfd_state = 1'b1;
      LOAD_DATA:          begin ld_state = 1'b1; we_reg = 1'b1; busy = 1'b0; end
      FIFO_FULL_STATE:    full_state = 1'b1;
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; we_reg = 1'b1; end
      LOAD_PARITY:        we_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default:            busy = 1'b1;
    endcase
  end

endmodule
